// File: rtl/bus_sequencer_if.sv
// Instruction handshake and datapath control bus between the sequencer and the CPU datapath.
// An instruction transfers on a rising edge where instr_valid and instr_ready are both 1; instr_valid may stay high, and ready rises only in IDLE.
interface bus_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic       imm_instruction;
  logic [3:0] data_bus_sel;
  logic       pc_load_en;
  logic       ir_load_en;
  logic       sel_field_load_en;
  logic       alu_src1_load_en;
  logic       alu_src2_load_en;
  logic       rf_write_read;

  modport master (
    input  instr_valid, imm_instruction,
    output instr_ready, data_bus_sel, pc_load_en, ir_load_en, sel_field_load_en,
           alu_src1_load_en, alu_src2_load_en, rf_write_read
  );

  modport slave (
    output instr_valid, imm_instruction,
    input  instr_ready, data_bus_sel, pc_load_en, ir_load_en, sel_field_load_en,
           alu_src1_load_en, alu_src2_load_en, rf_write_read
  );
endinterface

// File: rtl/bus_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through operand select/read,
// write-back and PC increment on a shared data bus, with optional single-step halting.
module bus_sequencer (
  input  logic                   clk,
  input  logic                   rst_n,
  bus_sequencer_if.master        bus,
  input  logic                   step_mode,
  input  logic                   step_req,
  output logic                   busy,
  output logic [3:0]             state_out,
  output logic [7:0]             retired_count
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SEL1  = 4'd1,
    S_RD1   = 4'd2,
    S_SEL2  = 4'd3,
    S_RD2   = 4'd4,
    S_SELD  = 4'd5,
    S_WB    = 4'd6,
    S_PCINC = 4'd7,
    S_HALT  = 4'd8
  } state_t;

  localparam logic [3:0] BUS_PC_PLUS_4 = 4'd1;
  localparam logic [3:0] BUS_IR_R1     = 4'd3;
  localparam logic [3:0] BUS_IR_R2     = 4'd4;
  localparam logic [3:0] BUS_IR_RD     = 4'd5;
  localparam logic [3:0] BUS_ALU       = 4'd6;
  localparam logic [3:0] BUS_RF        = 4'd7;
  localparam logic [3:0] BUS_NOP       = 4'd8;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      retired_count <= 8'd0;
    end else begin
      state <= next_state;
      if (state == S_PCINC) retired_count <= retired_count + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.instr_valid) next_state = S_SEL1;
      S_SEL1:  next_state = S_RD1;
      S_RD1:   next_state = S_SEL2;
      S_SEL2:  next_state = bus.imm_instruction ? S_SELD : S_RD2;
      S_RD2:   next_state = S_SELD;
      S_SELD:  next_state = S_WB;
      S_WB:    next_state = S_PCINC;
      S_PCINC: next_state = step_mode ? S_HALT : S_IDLE;
      S_HALT:  if (step_req || !step_mode) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Purely decoded from state and live inputs so reset silences every strobe without a clock edge.
  always_comb begin
    bus.instr_ready       = 1'b0;
    bus.data_bus_sel      = BUS_NOP;
    bus.pc_load_en        = 1'b0;
    bus.ir_load_en        = 1'b0;
    bus.sel_field_load_en = 1'b0;
    bus.alu_src1_load_en  = 1'b0;
    bus.alu_src2_load_en  = 1'b0;
    bus.rf_write_read     = 1'b0;
    busy                  = 1'b0;
    case (state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        bus.ir_load_en  = bus.instr_valid;
      end
      S_SEL1: begin
        bus.data_bus_sel      = BUS_IR_R1;
        bus.sel_field_load_en = 1'b1;
        busy                  = 1'b1;
      end
      S_RD1: begin
        bus.data_bus_sel     = BUS_RF;
        bus.alu_src1_load_en = 1'b1;
        busy                 = 1'b1;
      end
      S_SEL2: begin
        bus.data_bus_sel      = BUS_IR_R2;
        bus.alu_src2_load_en  = bus.imm_instruction;
        bus.sel_field_load_en = !bus.imm_instruction;
        busy                  = 1'b1;
      end
      S_RD2: begin
        bus.data_bus_sel     = BUS_RF;
        bus.alu_src2_load_en = 1'b1;
        busy                 = 1'b1;
      end
      S_SELD: begin
        bus.data_bus_sel      = BUS_IR_RD;
        bus.sel_field_load_en = 1'b1;
        busy                  = 1'b1;
      end
      S_WB: begin
        bus.data_bus_sel  = BUS_ALU;
        bus.rf_write_read = 1'b1;
        busy              = 1'b1;
      end
      S_PCINC: begin
        bus.data_bus_sel = BUS_PC_PLUS_4;
        bus.pc_load_en   = 1'b1;
        busy             = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized bench for bus_sequencer: an instruction-level reference model (queue of pending
// micro-steps per instruction) checked every cycle, plus directed literal sequences.
module tb_bus_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       step_mode = 1'b0;
  logic       step_req = 1'b0;
  logic       busy;
  logic [3:0] state_out;
  logic [7:0] retired_count;

  bus_sequencer_if bus ();

  bus_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.master),
    .step_mode     (step_mode),
    .step_req      (step_req),
    .busy          (busy),
    .state_out     (state_out),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining micro-steps of the instruction in flight, halt flag, retire count.
  int prog[$];
  bit m_halt;
  int m_retired;

  int obs_state[$];
  int obs_bus[$];
  int obs_ready[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_state();
    if (m_halt) return 8;
    if (prog.size() == 0) return 0;
    return prog[0];
  endfunction

  function automatic logic [5:0] dut_strobes();
    return {bus.pc_load_en, bus.ir_load_en, bus.sel_field_load_en,
            bus.alu_src1_load_en, bus.alu_src2_load_en, bus.rf_write_read};
  endfunction

  task automatic compare_model();
    int st;
    int eb;
    logic [5:0] es; // {pc, ir, sel, src1, src2, rf_write}
    st = m_state();
    eb = 8;
    es = '0;
    case (st)
      0: es[4] = bus.instr_valid;
      1: begin eb = 3; es[3] = 1'b1; end
      2: begin eb = 7; es[2] = 1'b1; end
      3: begin eb = 4; if (bus.imm_instruction) es[1] = 1'b1; else es[3] = 1'b1; end
      4: begin eb = 7; es[1] = 1'b1; end
      5: begin eb = 5; es[3] = 1'b1; end
      6: begin eb = 6; es[0] = 1'b1; end
      7: begin eb = 1; es[5] = 1'b1; end
      default: ;
    endcase
    chk("state_out", state_out, st);
    chk("data_bus_sel", bus.data_bus_sel, eb);
    chk("strobes", dut_strobes(), es);
    chk("instr_ready", bus.instr_ready, (st == 0));
    chk("busy", busy, (st >= 1 && st <= 7));
    chk("retired_count", retired_count, m_retired);
    chk("one_strobe", ($countones(dut_strobes()) <= 1), 1);
  endtask

  task automatic model_advance();
    int h;
    if (m_halt) begin
      if (step_req || !step_mode) m_halt = 1'b0;
    end else if (prog.size() == 0) begin
      if (bus.instr_valid) prog = '{1, 2, 3, 4, 5, 6, 7};
    end else begin
      h = prog.pop_front();
      if (h == 3 && bus.imm_instruction) h = prog.pop_front();
      if (h == 7) begin
        m_retired = (m_retired + 1) % 256;
        if (step_mode) m_halt = 1'b1;
      end
    end
  endtask

  // Called at posedge+1; drives inputs, checks at posedge+3, advances model, returns at next posedge+1.
  task automatic cycle(input logic v, input logic imm, input logic sm, input logic sr);
    bus.instr_valid     = v;
    bus.imm_instruction = imm;
    step_mode           = sm;
    step_req            = sr;
    #2;
    compare_model();
    obs_state.push_back(int'(state_out));
    obs_bus.push_back(int'(bus.data_bus_sel));
    obs_ready.push_back(int'(bus.instr_ready));
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    prog.delete();
    m_halt = 1'b0;
    m_retired = 0;
  endtask

  task automatic do_reset();
    bus.instr_valid = 1'b0;
    bus.imm_instruction = 1'b0;
    step_mode = 1'b0;
    step_req = 1'b0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_state", state_out, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_bus_sel", bus.data_bus_sel, 8);
    chk("rst_strobes", dut_strobes(), 0);
    chk("rst_busy", busy, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic obs_clear();
    obs_state.delete();
    obs_bus.delete();
    obs_ready.delete();
  endtask

  initial begin
    int exp_st_reg[9];
    int exp_bus_reg[9];
    int exp_st_imm[8];
    int exp_st_halt[7];

    exp_st_reg  = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    exp_bus_reg = '{8, 3, 7, 4, 7, 5, 6, 1, 8};
    exp_st_imm  = '{0, 1, 2, 3, 5, 6, 7, 0};
    exp_st_halt = '{8, 8, 8, 8, 8, 8, 0};

    bus.instr_valid = 1'b0;
    bus.imm_instruction = 1'b0;
    do_reset();

    // Register op with instr_valid held: second accept lands on the IDLE visit.
    obs_clear();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ret_after_first", retired_count, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("reg_seq_state", obs_state[i], exp_st_reg[i]);
      chk("reg_seq_bus", obs_bus[i], exp_bus_reg[i]);
    end
    for (int i = 1; i < 8; i++) chk("reg_latency_ready_low", obs_ready[i], 0);
    chk("reg_latency_ready_at_8", obs_ready[8], 1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Immediate op skips RD2.
    obs_clear();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) chk("imm_seq_state", obs_state[i], exp_st_imm[i]);
    chk("imm_sel2_bus", obs_bus[3], 4);
    for (int i = 1; i < 7; i++) chk("imm_latency_ready_low", obs_ready[i], 0);
    chk("imm_latency_ready_at_7", obs_ready[7], 1);
    chk("ret_after_imm", retired_count, 3);

    // Single-step: halt after retirement until step_req.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    obs_clear();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) chk("halt_seq_state", obs_state[i], exp_st_halt[i]);
    for (int i = 0; i < 6; i++) chk("halt_ready_low", obs_ready[i], 0);

    // step_req outside HALT has no effect.
    obs_clear();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) chk("idle_step_req_state", obs_state[i], 0);

    // Asynchronous reset while in WB.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("wb_reached", state_out, 6);
    chk("wb_rf_write", bus.rf_write_read, 1);
    chk("wb_retired_before", retired_count, 4);
    rst_n = 1'b0;
    #1;
    chk("wb_rst_state", state_out, 0);
    chk("wb_rst_rf_write", bus.rf_write_read, 0);
    chk("wb_rst_retired", retired_count, 0);
    chk("wb_rst_strobes", dut_strobes(), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 256 back-to-back register ops wrap the retire counter.
    for (int i = 0; i < 256 * 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_retired", retired_count, 0);
    chk("wrap_state", state_out, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port instr_valid  input  1  instruction word present on the CPU instruction pins.
REQ-004 SHALL have port instr_ready  output  1  sequencer accepts an instruction this cycle.
REQ-005 SHALL have port imm_instruction  input  1  the decoded IR opcode is ADDI; sampled only in state SEL2.
REQ-006 SHALL have port step_mode  input  1  when 1, halt after each retired instruction.
REQ-007 SHALL have port step_req  input  1  release from HALT.
REQ-008 SHALL have port data_bus_sel  output  4  common-bus source. Encoding: PC=0, PC_PLUS_4=1, IR_OP=2, IR_R1=3, IR_R2=4, IR_RD=5, ALU_BUS=6, RF=7, NOP=8.
REQ-009 SHALL have ports pc_load_en, ir_load_en, sel_field_load_en, alu_src1_load_en, alu_src2_load_en  output  1 each  register load strobes.
REQ-010 SHALL have port rf_write_read  output  1  1 = register-file write of data_bus, 0 = read.
REQ-011 SHALL have port busy  output  1  instruction in flight.
REQ-012 SHALL have port state_out  output  4  current state encoding (debug).
REQ-013 SHALL have port retired_count  output  8  count of completed instructions.

Function
REQ-014 SHALL implement states IDLE=0, SEL1=1, RD1=2, SEL2=3, RD2=4, SELD=5, WB=6, PCINC=7, HALT=8; state_out SHALL equal the current state.
REQ-015 IDLE: instr_ready=1, data_bus_sel=NOP. If instr_valid=1: ir_load_en=1 that same cycle; next state SEL1. Otherwise stay in IDLE.
REQ-016 SEL1: data_bus_sel=IR_R1, sel_field_load_en=1; next state RD1.
REQ-017 RD1: data_bus_sel=RF, alu_src1_load_en=1; next state SEL2.
REQ-018 SEL2: data_bus_sel=IR_R2. If imm_instruction=1: alu_src2_load_en=1; next state SELD. Otherwise: sel_field_load_en=1; next state RD2.
REQ-019 RD2: data_bus_sel=RF, alu_src2_load_en=1; next state SELD.
REQ-020 SELD: data_bus_sel=IR_RD, sel_field_load_en=1; next state WB.
REQ-021 WB: data_bus_sel=ALU_BUS, rf_write_read=1; next state PCINC.
REQ-022 PCINC: data_bus_sel=PC_PLUS_4, pc_load_en=1; retired_count increments. Next state is HALT if step_mode=1, else IDLE.
REQ-023 HALT: data_bus_sel=NOP, all strobes 0, instr_ready=0. Next state is IDLE if step_req=1 or step_mode=0.
REQ-024 Every output or strobe not named for a state SHALL be 0 in that state; at most one of the five load strobes and rf_write_read SHALL be 1 in any cycle.
REQ-025 Outputs SHALL be decoded from state plus current inputs (Mealy only for ir_load_en/instr_ready in IDLE and the SEL2 branch); no output registers.
REQ-026 Latency from the accept cycle to the next instr_ready=1 SHALL be 8 cycles for register ops and 7 for immediate ops (step_mode=0).
REQ-027 busy SHALL be 1 in states SEL1..PCINC and 0 in IDLE and HALT.
REQ-028 retired_count SHALL wrap 255 -> 0 with no flag.
REQ-029 instr_valid SHALL be ignored outside IDLE; holding it high across retirement SHALL cause back-to-back acceptance on each IDLE visit.
REQ-030 step_req in any state other than HALT SHALL have no effect.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE and retired_count=0; all strobes 0, rf_write_read=0, and data_bus_sel=NOP apart from the IDLE Mealy terms.
REQ-032 Reset asserted mid-instruction (e.g. in WB) SHALL abort with no further strobe; the same cycle rf_write_read SHALL drop to 0.
REQ-033 After rst_n rises, the first accept SHALL occur at the first clk edge at which instr_valid=1.

Verification
REQ-034 Reset then instr_valid=1 held with imm_instruction=0 -> state sequence 0,1,2,3,4,5,6,7,0; bus_sel 8,3,7,4,7,5,6,1; retired_count=1.
REQ-035 ADDI (imm_instruction=1 in SEL2) -> RD2 skipped; alu_src2_load_en asserted in SEL2 with bus_sel=4; next instr_ready 7 cycles after accept.
REQ-036 step_mode=1, one instruction -> HALT (state_out=8), busy=0, instr_ready=0 for 5 cycles; step_req pulse -> IDLE the next cycle.
REQ-037 256 back-to-back instructions -> retired_count reads 0; every cycle has at most one strobe high.
REQ-038 rst_n pulsed low between edges while in WB -> rf_write_read=0 and state_out=0 before the next edge; retired_count=0.
REQ-039 step_req pulsed in IDLE with instr_valid=0 -> no state change and no strobe.
